// File: rtl/alu_issue_stage.sv
// RV64I integer ALU issue stage: decodes one instruction into ALU operands
// and holds the result in a single-entry valid/ready output register.
module alu_issue_stage (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_instr,
  input  logic [63:0] in_pc,
  input  logic [63:0] in_rs1,
  input  logic [63:0] in_rs2,
  input  logic        flush,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] out_operand1,
  output logic [63:0] out_operand2,
  output logic [2:0]  out_operation,
  output logic        out_modify,
  output logic        out_cast_word,
  output logic [4:0]  out_rd,
  output logic        out_rd_we,
  output logic        out_illegal
);

  typedef struct packed {
    logic [63:0] op1;
    logic [63:0] op2;
    logic [2:0]  operation;
    logic        modify;
    logic        cast_word;
    logic [4:0]  rd;
    logic        rd_we;
    logic        illegal;
  } alu_op_t;

  alu_op_t dec;
  alu_op_t q;
  logic    vld;

  logic [6:0]  opc;
  logic [2:0]  f3;
  logic [6:0]  f7;
  logic [63:0] imm_i;
  logic [63:0] imm_u;
  logic [63:0] w_src;
  logic        sh;
  logic        is_lui;
  logic        is_auipc;
  logic        is_op_imm;
  logic        is_op;
  logic        is_op_imm_32;
  logic        is_op_32;

  assign opc   = in_instr[6:0];
  assign f3    = in_instr[14:12];
  assign f7    = in_instr[31:25];
  assign imm_i = {{52{in_instr[31]}}, in_instr[31:20]};
  assign imm_u = {{32{in_instr[31]}}, in_instr[31:12], 12'b0};
  assign sh    = (f3 == 3'd1) || (f3 == 3'd5);

  assign is_lui       = (opc == 7'b0110111);
  assign is_auipc     = (opc == 7'b0010111);
  assign is_op_imm    = (opc == 7'b0010011);
  assign is_op        = (opc == 7'b0110011);
  assign is_op_imm_32 = (opc == 7'b0011011);
  assign is_op_32     = (opc == 7'b0111011);

  // word right shifts see only the low half, extended per arithmetic/logical
  always_comb begin
    w_src = in_rs1;
    if (f3 == 3'd5) begin
      if (in_instr[30])
        w_src = {{32{in_rs1[31]}}, in_rs1[31:0]};
      else
        w_src = {32'b0, in_rs1[31:0]};
    end
  end

  logic        legal;
  logic [63:0] op1;
  logic [63:0] op2;
  logic [2:0]  oper;
  logic        mdf;
  logic        cw;

  always_comb begin
    legal = 1'b0;
    op1   = '0;
    op2   = '0;
    oper  = '0;
    mdf   = 1'b0;
    cw    = 1'b0;
    unique case (1'b1)
      is_lui: begin
        legal = 1'b1;
        op2   = imm_u;
      end
      is_auipc: begin
        legal = 1'b1;
        op1   = in_pc;
        op2   = imm_u;
      end
      is_op_imm: begin
        if (f3 == 3'd1)
          legal = (in_instr[31:26] == 6'h00);
        else if (f3 == 3'd5)
          legal = (in_instr[31:26] == 6'h00) ||
                  (in_instr[31:26] == 6'h10);
        else
          legal = 1'b1;
        op1  = in_rs1;
        op2  = sh ? {58'b0, in_instr[25:20]} : imm_i;
        oper = f3;
        mdf  = (f3 == 3'd5) && in_instr[30];
      end
      is_op: begin
        legal = (f7 == 7'h00) ||
                ((f7 == 7'h20) && ((f3 == 3'd0) || (f3 == 3'd5)));
        op1  = in_rs1;
        op2  = sh ? {58'b0, in_rs2[5:0]} : in_rs2;
        oper = f3;
        mdf  = in_instr[30];
      end
      is_op_imm_32: begin
        legal = (f3 == 3'd0) ||
                ((f3 == 3'd1) && (f7 == 7'h00)) ||
                ((f3 == 3'd5) && ((f7 == 7'h00) || (f7 == 7'h20)));
        op1  = w_src;
        op2  = sh ? {59'b0, in_instr[24:20]} : imm_i;
        oper = f3;
        mdf  = (f3 == 3'd5) && in_instr[30];
        cw   = 1'b1;
      end
      is_op_32: begin
        legal = ((f7 == 7'h00) &&
                 ((f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd5))) ||
                ((f7 == 7'h20) && ((f3 == 3'd0) || (f3 == 3'd5)));
        op1  = w_src;
        op2  = sh ? {59'b0, in_rs2[4:0]} : in_rs2;
        oper = f3;
        mdf  = in_instr[30];
        cw   = 1'b1;
      end
      default: legal = 1'b0;
    endcase
  end

  always_comb begin
    dec         = '0;
    dec.rd      = in_instr[11:7];
    dec.illegal = !legal;
    dec.rd_we   = legal && (in_instr[11:7] != 5'd0);
    if (legal) begin
      dec.op1       = op1;
      dec.op2       = op2;
      dec.operation = oper;
      dec.modify    = mdf;
      dec.cast_word = cw;
    end
  end

  logic xfer;

  assign in_ready = !vld || out_ready;
  assign xfer     = in_valid && in_ready;

  // flushed transfers complete the handshake but never reach the register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld <= 1'b0;
      q   <= '0;
    end else begin
      if (flush)
        vld <= 1'b0;
      else if (xfer)
        vld <= 1'b1;
      else if (out_ready)
        vld <= 1'b0;
      if (xfer && !flush)
        q <= dec;
    end
  end

  assign out_valid     = vld;
  assign out_operand1  = q.op1;
  assign out_operand2  = q.op2;
  assign out_operation = q.operation;
  assign out_modify    = q.modify;
  assign out_cast_word = q.cast_word;
  assign out_rd        = q.rd;
  assign out_rd_we     = q.rd_we;
  assign out_illegal   = q.illegal;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Bench for alu_issue_stage: directed cases plus random traffic
// compared against an instruction-level reference model.
module tb_alu_issue_stage;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic [63:0] in_pc;
  logic [63:0] in_rs1;
  logic [63:0] in_rs2;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_operand1;
  logic [63:0] out_operand2;
  logic [2:0]  out_operation;
  logic        out_modify;
  logic        out_cast_word;
  logic [4:0]  out_rd;
  logic        out_rd_we;
  logic        out_illegal;

  alu_issue_stage dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_instr      (in_instr),
    .in_pc         (in_pc),
    .in_rs1        (in_rs1),
    .in_rs2        (in_rs2),
    .flush         (flush),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_operand1  (out_operand1),
    .out_operand2  (out_operand2),
    .out_operation (out_operation),
    .out_modify    (out_modify),
    .out_cast_word (out_cast_word),
    .out_rd        (out_rd),
    .out_rd_we     (out_rd_we),
    .out_illegal   (out_illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [63:0] op1;
    logic [63:0] op2;
    logic [2:0]  operation;
    logic        modify;
    logic        cast;
    logic [4:0]  rd;
    logic        rd_we;
    logic        illegal;
  } exp_t;

  int   n_checks;
  int   n_errors;
  logic m_valid;
  exp_t m_exp;

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // instruction-level meaning of each RV64I ALU class
  function automatic exp_t ref_op(input logic [31:0] i,
                                  input logic [63:0] pc,
                                  input logic [63:0] r1,
                                  input logic [63:0] r2);
    exp_t        e;
    logic [6:0]  opc;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic        ill;
    logic        word;
    logic        isimm;
    logic        isreg;
    logic [63:0] b;
    e     = '0;
    opc   = i[6:0];
    f3    = i[14:12];
    f7    = i[31:25];
    ill   = 1'b0;
    word  = (opc == 7'h1B) || (opc == 7'h3B);
    isimm = (opc == 7'h13) || (opc == 7'h1B);
    isreg = (opc == 7'h33) || (opc == 7'h3B);
    e.rd  = i[11:7];
    if (opc == 7'h37 || opc == 7'h17) begin
      e.op1 = (opc == 7'h17) ? pc : 64'd0;
      e.op2 = 64'($signed({i[31:12], 12'h000}));
    end else if (isimm || isreg) begin
      if (word && !(f3 == 0 || f3 == 1 || f3 == 5)) ill = 1'b1;
      if (isreg && f7 != 7'h00 && f7 != 7'h20) ill = 1'b1;
      if (isreg && f7 == 7'h20 && f3 != 0 && f3 != 5) ill = 1'b1;
      if (isimm && !word) begin
        if (f3 == 1 && i[31:26] != 0) ill = 1'b1;
        if (f3 == 5 && i[31:26] != 0 && i[31:26] != 6'h10) ill = 1'b1;
      end
      if (isimm && word) begin
        if (f3 == 1 && f7 != 0) ill = 1'b1;
        if (f3 == 5 && f7 != 0 && f7 != 7'h20) ill = 1'b1;
      end
      e.operation = f3;
      e.cast      = word;
      e.modify    = isreg ? i[30] : (f3 == 5 && i[30]);
      e.op1       = r1;
      b = isreg ? r2 : 64'($signed(i[31:20]));
      if (f3 == 1 || f3 == 5)
        b = word ? (b % 32) : (b % 64);
      if (word && f3 == 5)
        e.op1 = e.modify ? 64'($signed(r1[31:0])) : 64'(r1[31:0]);
      e.op2 = b;
    end else begin
      ill = 1'b1;
    end
    if (ill) begin
      e         = '0;
      e.rd      = i[11:7];
      e.illegal = 1'b1;
    end else begin
      e.rd_we = (e.rd != 0);
    end
    return e;
  endfunction

  task automatic check_outs();
    logic bad;
    check("out_valid", 64'(out_valid), 64'(m_valid));
    if (m_valid) begin
      check("operand1", out_operand1, m_exp.op1);
      check("operand2", out_operand2, m_exp.op2);
      check("operation", 64'(out_operation), 64'(m_exp.operation));
      check("modify", 64'(out_modify), 64'(m_exp.modify));
      check("cast_word", 64'(out_cast_word), 64'(m_exp.cast));
      check("rd", 64'(out_rd), 64'(m_exp.rd));
      check("rd_we", 64'(out_rd_we), 64'(m_exp.rd_we));
      check("illegal", 64'(out_illegal), 64'(m_exp.illegal));
      bad = out_modify && (out_operation == 3'd2 ||
            out_operation == 3'd3 || out_operation == 3'd7);
      check("no_bad_modify", 64'(bad), 64'd0);
    end
  endtask

  // one clock: drive after negedge, model at posedge, compare at negedge
  task automatic cycle(input logic iv, input logic [31:0] ins,
                       input logic [63:0] pc, input logic [63:0] r1,
                       input logic [63:0] r2, input logic ordy,
                       input logic fl);
    logic rdy;
    logic xfer;
    exp_t e;
    in_valid  = iv;
    in_instr  = ins;
    in_pc     = pc;
    in_rs1    = r1;
    in_rs2    = r2;
    out_ready = ordy;
    flush     = fl;
    #1;
    rdy = !m_valid || ordy;
    check("in_ready", 64'(in_ready), 64'(rdy));
    xfer = iv && rdy;
    e    = ref_op(ins, pc, r1, r2);
    @(posedge clk);
    if (fl)
      m_valid = 1'b0;
    else if (xfer) begin
      m_valid = 1'b1;
      m_exp   = e;
    end else if (ordy)
      m_valid = 1'b0;
    @(negedge clk);
    check_outs();
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] i;
    logic [6:0]  opcs [6];
    opcs = '{7'h13, 7'h33, 7'h1B, 7'h3B, 7'h37, 7'h17};
    i = $urandom;
    if ($urandom_range(0, 7) != 0)
      i[6:0] = opcs[$urandom_range(0, 5)];
    if ($urandom_range(0, 1) == 1) begin
      i[31:25] = ($urandom_range(0, 1) == 1) ? 7'h20 : 7'h00;
      if ($urandom_range(0, 3) == 0) i[25] = 1'b1;
    end
    return i;
  endfunction

  initial begin
    n_checks  = 0;
    n_errors  = 0;
    m_valid   = 1'b0;
    m_exp     = '0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_instr  = '0;
    in_pc     = '0;
    in_rs1    = '0;
    in_rs2    = '0;
    out_ready = 1'b0;
    flush     = 1'b0;
    #12;
    check("rst_valid", 64'(out_valid), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_op1", out_operand1, 64'd0);
    check("rst_op2", out_operand2, 64'd0);
    check("rst_rd", 64'(out_rd), 64'd0);
    check("rst_illegal", 64'(out_illegal), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    cycle(1, 32'h402081B3, 0, 64'd5, 64'd7, 1, 0);
    check("sub_valid", 64'(out_valid), 64'd1);
    check("sub_op1", out_operand1, 64'd5);
    check("sub_op2", out_operand2, 64'd7);
    check("sub_modify", 64'(out_modify), 64'd1);
    check("sub_rd", 64'(out_rd), 64'd3);
    check("sub_rd_we", 64'(out_rd_we), 64'd1);

    cycle(1, 32'h4043529B, 0, 64'hFFFFFFFF_80000000, 0, 1, 0);
    check("sraiw_op1", out_operand1, 64'hFFFFFFFF_80000000);
    check("sraiw_op2", out_operand2, 64'd4);
    check("sraiw_oper", 64'(out_operation), 64'd5);
    check("sraiw_cast", 64'(out_cast_word), 64'd1);
    cycle(1, 32'h0043529B, 0, 64'hFFFFFFFF_80000000, 0, 1, 0);
    check("srliw_op1", out_operand1, 64'h00000000_80000000);
    check("srliw_modify", 64'(out_modify), 64'd0);

    cycle(1, 32'h80000097, 64'h1000, 64'd9, 64'd9, 1, 0);
    check("auipc_op1", out_operand1, 64'h1000);
    check("auipc_op2", out_operand2, 64'hFFFFFFFF_80000000);
    check("auipc_rd", 64'(out_rd), 64'd1);

    cycle(1, 32'h0000007F, 0, 64'd3, 64'd4, 1, 0);
    check("ill_flag", 64'(out_illegal), 64'd1);
    check("ill_rd_we", 64'(out_rd_we), 64'd0);
    check("ill_op1", out_operand1, 64'd0);
    cycle(1, 32'h0200909B, 0, 64'd3, 64'd4, 1, 0);
    check("slliw_ill", 64'(out_illegal), 64'd1);
    check("slliw_op2", out_operand2, 64'd0);

    cycle(1, 32'hFFF00093, 0, 64'd1, 64'd2, 1, 0);
    for (int k = 0; k < 3; k++) begin
      cycle(1, 32'h00100113, 0, 64'd1, 64'd2, 0, 0);
      check("bp_op2", out_operand2, 64'hFFFFFFFF_FFFFFFFF);
      check("bp_rd", 64'(out_rd), 64'd1);
    end
    cycle(1, 32'h00100113, 0, 64'd1, 64'd2, 1, 0);
    check("bp_next_op2", out_operand2, 64'd1);
    check("bp_next_rd", 64'(out_rd), 64'd2);

    cycle(0, 32'h00100113, 0, 0, 0, 1, 0);
    cycle(1, 32'h402081B3, 0, 64'd5, 64'd7, 1, 0);
    cycle(1, 32'hFFF00093, 0, 0, 0, 0, 1);
    check("flush_held", 64'(out_valid), 64'd0);
    cycle(1, 32'hFFF00093, 0, 0, 0, 1, 1);
    check("flush_xfer", 64'(out_valid), 64'd0);

    cycle(1, 32'h402081B3, 0, 64'd5, 64'd7, 1, 0);
    cycle(1, 32'hFFF00093, 0, 0, 0, 0, 0);
    #2;
    rst_n = 1'b0;
    #1;
    m_valid = 1'b0;
    check("arst_valid", 64'(out_valid), 64'd0);
    check("arst_in_ready", 64'(in_ready), 64'd1);
    check("arst_op1", out_operand1, 64'd0);
    check("arst_rd", 64'(out_rd), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    cycle(1, 32'h402081B3, 0, 64'd5, 64'd7, 1, 0);
    check("post_rst_valid", 64'(out_valid), 64'd1);

    for (int n = 0; n < 3000; n++) begin
      cycle($urandom_range(0, 3) != 0, rand_instr(),
            {$urandom, $urandom}, {$urandom, $urandom},
            {$urandom, $urandom}, $urandom_range(0, 9) < 7,
            $urandom_range(0, 19) == 0);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
